// File: rtl/cpu_pkg.sv
// Shared CPU types: ALU opcodes, sequencer FSM states and datapath sizes.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 2;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    NOT = 3'd2,
    AND = 3'd3,
    OR  = 3'd4,
    XOR = 3'd5,
    INC = 3'd6,
    DEC = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    WAIT = 3'd3,
    WB   = 3'd4
  } alu_seq_state_e;

  function automatic logic op_sets_carry(input alu_op_e op);
    return (op == ADD) || (op == SUB) || (op == INC) || (op == DEC);
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Multi-cycle sequencer: one reg-to-reg ALU instruction at a time, done at accept+2+ALU_LATENCY.
// Optional macro ALU_SEQ_CMP_EN adds req_cmp (compare/test: flags and done, no write-back).
module alu_seq #(
  parameter int DATA_W      = 8,
  parameter int REG_AW      = 2,
  parameter int ALU_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [REG_AW-1:0] req_ra,
  input  logic [REG_AW-1:0] req_rb,
  input  logic              req_use_imm,
  input  logic [DATA_W-1:0] req_imm,
`ifdef ALU_SEQ_CMP_EN
  input  logic              req_cmp,
`endif
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              alu_en,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              flag_z,
  output logic              flag_c,
  output logic              done
);
  import cpu_pkg::*;

  localparam int CW = $clog2(ALU_LATENCY + 1);

  alu_seq_state_e    state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  alu_op_e           op_q;
  logic [REG_AW-1:0] rd_q, ra_q, rb_q;
  logic              use_imm_q;
  logic [DATA_W-1:0] imm_q, a_q, b_q;
  logic              flag_z_q, flag_c_q;
  logic              wb_write;
  logic              accept;

  assign accept = req_valid && req_ready;

`ifdef ALU_SEQ_CMP_EN
  logic cmp_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cmp_q <= 1'b0;
    else if (accept) cmp_q <= req_cmp;
  end
  assign wb_write = !cmp_q;
`else
  assign wb_write = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= ADD;
      rd_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q      <= alu_op_e'(req_op);
        rd_q      <= req_rd;
        ra_q      <= req_ra;
        rb_q      <= req_rb;
        use_imm_q <= req_use_imm;
        imm_q     <= req_imm;
      end
      // Operands are captured at the end of READ and held through WAIT.
      if (state_q == READ) begin
        a_q <= rf_rdata_a;
        b_q <= use_imm_q ? imm_q : rf_rdata_b;
      end
      if (state_q == WB) begin
        flag_z_q <= (alu_out == '0);
        flag_c_q <= op_sets_carry(op_q) && alu_carry;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    alu_en    = 1'b0;
    rf_we     = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = READ;
      end
      READ: state_d = EXEC;
      EXEC: begin
        alu_en  = 1'b1;
        cnt_d   = CW'(1);
        state_d = (ALU_LATENCY == 1) ? WB : WAIT;
      end
      WAIT: begin
        if (cnt_q >= CW'(ALU_LATENCY - 1)) state_d = WB;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      WB: begin
        rf_we   = wb_write;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rf_raddr_a = ra_q;
  assign rf_raddr_b = rb_q;
  assign rf_waddr   = rd_q;
  assign rf_wdata   = (state_q == WB) ? alu_out : '0;
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign flag_z     = flag_z_q;
  assign flag_c     = flag_c_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: latency-1 and latency-3 instances, behavioural ALU/regfile, directed + random checks.
module tb_alu_seq;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic force_c = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rq_valid = 1'b0, rq_ui = 1'b0, rq_cmp = 1'b0;
  logic [2:0] rq_op = 3'd0;
  logic [1:0] rq_rd = 2'd0, rq_ra = 2'd0, rq_rb = 2'd0;
  logic [7:0] rq_imm = 8'd0;
  logic       ready1, we1, en1, fz1, fc1, done1, acar1;
  logic [1:0] raa1, rab1, wa1;
  logic [7:0] rda1, rdb1, wd1, aa1, ab1, aout1;
  logic [2:0] aop1;

  logic       r3_valid = 1'b0;
  logic [2:0] r3_op = 3'd0;
  logic [1:0] r3_rd = 2'd0, r3_ra = 2'd0, r3_rb = 2'd0;
  logic       ready3, we3, en3, fz3, fc3, done3, acar3;
  logic [1:0] raa3, rab3, wa3;
  logic [7:0] rda3, rdb3, wd3, aa3, ab3, aout3;
  logic [2:0] aop3;

  logic       ld_we = 1'b0;
  logic [1:0] ld_a = 2'd0;
  logic [7:0] ld_d = 8'd0;
  logic [7:0] rf [4];
  logic [7:0] rf3 [4];
  logic [7:0] ref_rf [4];

  alu_seq #(.DATA_W(8), .REG_AW(2), .ALU_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(rq_valid), .req_ready(ready1), .req_op(rq_op),
    .req_rd(rq_rd), .req_ra(rq_ra), .req_rb(rq_rb), .req_use_imm(rq_ui), .req_imm(rq_imm),
`ifdef ALU_SEQ_CMP_EN
    .req_cmp(rq_cmp),
`endif
    .rf_raddr_a(raa1), .rf_raddr_b(rab1), .rf_rdata_a(rda1), .rf_rdata_b(rdb1),
    .rf_we(we1), .rf_waddr(wa1), .rf_wdata(wd1), .alu_en(en1), .alu_op(aop1),
    .alu_a(aa1), .alu_b(ab1), .alu_out(aout1), .alu_carry(acar1),
    .flag_z(fz1), .flag_c(fc1), .done(done1)
  );

  alu_seq #(.DATA_W(8), .REG_AW(2), .ALU_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(r3_valid), .req_ready(ready3), .req_op(r3_op),
    .req_rd(r3_rd), .req_ra(r3_ra), .req_rb(r3_rb), .req_use_imm(1'b0), .req_imm(8'h00),
`ifdef ALU_SEQ_CMP_EN
    .req_cmp(1'b0),
`endif
    .rf_raddr_a(raa3), .rf_raddr_b(rab3), .rf_rdata_a(rda3), .rf_rdata_b(rdb3),
    .rf_we(we3), .rf_waddr(wa3), .rf_wdata(wd3), .alu_en(en3), .alu_op(aop3),
    .alu_a(aa3), .alu_b(ab3), .alu_out(aout3), .alu_carry(acar3),
    .flag_z(fz3), .flag_c(fc3), .done(done3)
  );

  // Behavioural ALU: {carry/borrow, result}.
  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {a < b, a - b};
      3'd2:    return {1'b0, ~a};
      3'd3:    return {1'b0, a & b};
      3'd4:    return {1'b0, a | b};
      3'd5:    return {1'b0, a ^ b};
      3'd6:    return {a == 8'hFF, a + 8'd1};
      default: return {a == 8'h00, a - 8'd1};
    endcase
  endfunction

  logic [8:0] p1 = 9'd0;
  logic [8:0] p3 [3];
  always @(posedge clk) begin
    if (en1) p1 <= alu_f(aop1, aa1, ab1) | {force_c, 8'h00};
    if (en3) p3[0] <= alu_f(aop3, aa3, ab3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign aout1 = p1[7:0];
  assign acar1 = p1[8];
  assign aout3 = p3[2][7:0];
  assign acar3 = p3[2][8];

  assign rda1 = rf[raa1];
  assign rdb1 = rf[rab1];
  assign rda3 = rf3[raa3];
  assign rdb3 = rf3[rab3];
  always @(posedge clk) begin
    if (ld_we) begin
      rf[ld_a]  <= ld_d;
      rf3[ld_a] <= ld_d;
    end else begin
      if (we1) rf[wa1]  <= wd1;
      if (we3) rf3[wa3] <= wd3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld_we = 1'b0;
    ref_rf[a] = d;
  endtask

  // Issue one instruction on the latency-1 instance and check it against the reference model.
  task automatic issue(input string tag, input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic ui, input logic [7:0] imm, input logic cmp);
    logic [7:0] a, b;
    logic [8:0] r;
    logic       exp_c, got;
    int         t0, en_cnt;
    a = ref_rf[ra];
    b = ui ? imm : ref_rf[rb];
    r = alu_f(op, a, b);
    exp_c = (op == 3'd0 || op == 3'd1 || op == 3'd6 || op == 3'd7) ? r[8] : 1'b0;
    @(negedge clk);
    rq_valid = 1'b1; rq_op = op; rq_rd = rd; rq_ra = ra; rq_rb = rb;
    rq_ui = ui; rq_imm = imm; rq_cmp = cmp;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (ready1) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_accept"}, 32'(got), 32'd1);
    t0 = cyc;
    @(negedge clk);
    rq_valid = 1'b0;
    en_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (en1) begin
        en_cnt++;
        chk({tag, "_alu_a"}, 32'(aa1), 32'(a));
        chk({tag, "_alu_b"}, 32'(ab1), 32'(b));
        chk({tag, "_alu_op"}, 32'(aop1), 32'(op));
      end
      if (done1) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc - t0), 32'd3);
    chk({tag, "_en_cnt"}, 32'(en_cnt), 32'd1);
    chk({tag, "_we"}, 32'(we1), 32'(!cmp));
    chk({tag, "_waddr"}, 32'(wa1), 32'(rd));
    chk({tag, "_wdata"}, 32'(wd1), 32'(r[7:0]));
    chk({tag, "_en_in_wb"}, 32'(en1), 32'd0);
    if (!cmp) ref_rf[rd] = r[7:0];
    @(negedge clk);
    chk({tag, "_flag_z"}, 32'(fz1), 32'(r[7:0] == 8'h00));
    chk({tag, "_flag_c"}, 32'(fc1), 32'(exp_c));
    chk({tag, "_ready"}, 32'(ready1), 32'd1);
    chk({tag, "_rf"}, 32'(rf[rd]), 32'(ref_rf[rd]));
  endtask

  initial begin
    logic       got;
    int         t0, n, en_cnt, overlap;
    int         acc [3];
    logic [2:0] op;
    logic [1:0] rd, ra, rb;
    logic       ui;
    logic [7:0] imm;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready1), 32'd1);
    chk("rst_we", 32'(we1), 32'd0);
    chk("rst_en", 32'(en1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_flags", 32'({fz1, fc1}), 32'd0);
    chk("rst_wdata", 32'(wd1), 32'd0);
    rst = 1'b0;

    load(2'd0, 8'hF0);
    load(2'd1, 8'h20);
    load(2'd2, 8'h55);
    load(2'd3, 8'h0F);

    // Latency-3 instance: SUB 0xF0-0x20 into r2.
    @(negedge clk);
    r3_valid = 1'b1; r3_op = 3'd1; r3_rd = 2'd2; r3_ra = 2'd0; r3_rb = 2'd1;
    chk("l3_ready", 32'(ready3), 32'd1);
    t0 = cyc;
    @(negedge clk);
    r3_valid = 1'b0;
    en_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (en3) en_cnt++;
      if (done3) got = 1'b1;
      else @(negedge clk);
    end
    chk("l3_done", 32'(got), 32'd1);
    chk("l3_latency", 32'(cyc - t0), 32'd5);
    chk("l3_en_cnt", 32'(en_cnt), 32'd1);
    chk("l3_we", 32'(we3), 32'd1);
    chk("l3_wdata", 32'(wd3), 32'h0D0);
    @(negedge clk);
    chk("l3_flags", 32'({fz3, fc3}), 32'd0);

    issue("add", 3'd0, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0);
    issue("sub_zero", 3'd1, 2'd1, 2'd2, 2'd2, 1'b0, 8'h00, 1'b0);
    issue("dec_borrow", 3'd7, 2'd2, 2'd1, 2'd0, 1'b0, 8'h00, 1'b0);

    // Reset while in EXEC: no write-back, flags cleared.
    chk("pre_rst_c", 32'(fc1), 32'd1);
    @(negedge clk);
    rq_valid = 1'b1; rq_op = 3'd0; rq_rd = 2'd0; rq_ra = 2'd2; rq_rb = 2'd2; rq_ui = 1'b0; rq_cmp = 1'b0;
    @(negedge clk);
    rq_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (en1) got = 1'b1;
      else @(negedge clk);
    end
    chk("rst_reach_exec", 32'(got), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(ready1), 32'd1);
    chk("midrst_flags", 32'({fz1, fc1}), 32'd0);
    chk("midrst_en", 32'(en1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (we1 || done1) n++;
    end
    chk("midrst_no_wb", 32'(n), 32'd0);
    chk("midrst_rf", 32'(rf[0]), 32'(ref_rf[0]));

    load(2'd3, 8'h0F);
    force_c = 1'b1;
    issue("xor_imm", 3'd5, 2'd0, 2'd3, 2'd1, 1'b1, 8'hFF, 1'b0);
    force_c = 1'b0;

    // Request held valid: accepts every 4 cycles, never while busy.
    @(negedge clk);
    rq_valid = 1'b1; rq_op = 3'd3; rq_rd = 2'd3; rq_ra = 2'd3; rq_rb = 2'd3; rq_ui = 1'b0;
    t0 = cyc;
    n = 0;
    overlap = 0;
    for (int i = 0; i < 11; i++) begin
      if (ready1) begin
        if (n < 3) acc[n] = cyc - t0;
        n++;
      end
      if (en1 && (we1 || done1)) overlap++;
      @(negedge clk);
    end
    rq_valid = 1'b0;
    chk("b2b_count", 32'(n), 32'd3);
    chk("b2b_acc0", 32'(acc[0]), 32'd0);
    chk("b2b_acc1", 32'(acc[1]), 32'd4);
    chk("b2b_acc2", 32'(acc[2]), 32'd8);
    chk("b2b_overlap", 32'(overlap), 32'd0);
    @(negedge clk);
    chk("b2b_ready", 32'(ready1), 32'd1);
    chk("b2b_flags", 32'({fz1, fc1}), 32'({ref_rf[3] == 8'h00, 1'b0}));

    for (int k = 0; k < 30; k++) begin
      op  = 3'($urandom_range(0, 7));
      rd  = 2'($urandom_range(0, 3));
      ra  = 2'($urandom_range(0, 3));
      rb  = 2'($urandom_range(0, 3));
      ui  = 1'($urandom_range(0, 1));
      imm = 8'($urandom_range(0, 255));
      issue("rand", op, rd, ra, rb, ui, imm, 1'b0);
    end

`ifdef ALU_SEQ_CMP_EN
    load(2'd2, 8'h10);
    issue("cmp_sub", 3'd1, 2'd1, 2'd2, 2'd2, 1'b0, 8'h00, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
